// File: rtl/m_stage_sched_pkg.sv
// m_stage_sched_pkg
// Shared constants for the SHA-256 message-schedule sequencer:
//   - FSM state encodings (plain localparams for legacy tools)
//   - accelerator unit indices for the four operand xregs and the result xreg
//   - schedule tap offsets (t-16, t-15, t-7, t-2)
//   - WR sub-phase encodings
//   - helpers that map the operand counter k to its tap offset / unit index
package m_stage_sched_pkg;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_WR    = 3'd1;
   localparam logic [2:0] ST_RUN   = 3'd2;
   localparam logic [2:0] ST_ARM   = 3'd3;
   localparam logic [2:0] ST_WAIT  = 3'd4;
   localparam logic [2:0] ST_RD    = 3'd5;
   localparam logic [2:0] ST_STORE = 3'd6;
   localparam logic [2:0] ST_FIN   = 3'd7;

   localparam logic [2:0] XREG_WM16 = 3'd0;
   localparam logic [2:0] XREG_WM15 = 3'd1;
   localparam logic [2:0] XREG_WM7  = 3'd2;
   localparam logic [2:0] XREG_WM2  = 3'd3;
   localparam logic [2:0] XREG_RES  = 3'd4;

   // Offsets fit in 6 bits; buffer indices are taken modulo 64.
   localparam logic [5:0] TAP_WM16 = 6'd16;
   localparam logic [5:0] TAP_WM15 = 6'd15;
   localparam logic [5:0] TAP_WM7  = 6'd7;
   localparam logic [5:0] TAP_WM2  = 6'd2;

   // WR sub-phases: present buffer address, load bus regs, hold until ack.
   localparam logic [1:0] WR_FETCH = 2'd0;
   localparam logic [1:0] WR_LOAD  = 2'd1;
   localparam logic [1:0] WR_HOLD  = 2'd2;

   function automatic logic [5:0] tap_of(input logic [1:0] k);
      case (k)
         2'd0:    tap_of = TAP_WM16;
         2'd1:    tap_of = TAP_WM15;
         2'd2:    tap_of = TAP_WM7;
         2'd3:    tap_of = TAP_WM2;
         default: tap_of = TAP_WM16;
      endcase
   endfunction

   function automatic logic [2:0] xreg_of(input logic [1:0] k);
      case (k)
         2'd0:    xreg_of = XREG_WM16;
         2'd1:    xreg_of = XREG_WM15;
         2'd2:    xreg_of = XREG_WM7;
         2'd3:    xreg_of = XREG_WM2;
         default: xreg_of = XREG_WM16;
      endcase
   endfunction

endpackage

// File: rtl/m_stage_sched_buf.sv
// m_stage_sched_buf
// 64-word schedule buffer: one write port, one synchronous read port.
// The memory array is not reset; the read-data register is.
// Ports:
//   clk, rst             clock, asynchronous active-low reset (read register only)
//   rd_en, rd_addr       read request; data appears on rd_data the next cycle
//   rd_data              registered read data (holds until the next read)
//   wr_en, wr_addr, wr_data  synchronous write
module m_stage_sched_buf #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rd_en,
   input  logic [5:0]        rd_addr,
   output logic [DATA_W-1:0] rd_data,
   input  logic              wr_en,
   input  logic [5:0]        wr_addr,
   input  logic [DATA_W-1:0] wr_data
);

   logic [DATA_W-1:0] mem_r [0:63];
   logic [DATA_W-1:0] rd_data_r;

   // memory write port
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_r[wr_addr] <= wr_data;
      end
   end

   // registered read port
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_data_r <= '0;
      end else if (rd_en) begin
         rd_data_r <= mem_r[rd_addr];
      end
   end

   assign rd_data = rd_data_r;

endmodule

// File: rtl/m_stage_sched.sv
// m_stage_sched
// Sequencer for the SHA-256 message-schedule accelerator. For t = 16..15+ROUNDS it
// writes W[t-16], W[t-15], W[t-7], W[t-2] to accelerator units 0..3, pulses run,
// waits for done, reads unit 4 and stores the result as W[t] in the local buffer.
// Ports:
//   clk, rst              clock, asynchronous active-low reset
//   start/busy/fin/err    control: start pulse, busy level, finish pulse, sticky timeout
//   h_valid/h_we/h_addr/h_wdata/h_rdata/h_ready   host buffer port (writes only when idle)
//   acc_valid/acc_addr/acc_wstrb/acc_wdata/acc_ready/acc_rdata  accelerator bus
//   acc_run/acc_done      accelerator run pulse and done level
// The host is expected to keep one request outstanding (wait for h_ready).
module m_stage_sched #(
   parameter int DATA_W     = 32,
   parameter int ACC_ADDR_W = 3,
   parameter int ROUNDS     = 48,
   parameter int TIMEOUT    = 1023
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   output logic                  busy,
   output logic                  fin,
   output logic                  err,
   input  logic                  h_valid,
   input  logic                  h_we,
   input  logic [5:0]            h_addr,
   input  logic [DATA_W-1:0]     h_wdata,
   output logic [DATA_W-1:0]     h_rdata,
   output logic                  h_ready,
   output logic                  acc_valid,
   output logic [ACC_ADDR_W-1:0] acc_addr,
   output logic [3:0]            acc_wstrb,
   output logic [DATA_W-1:0]     acc_wdata,
   input  logic                  acc_ready,
   input  logic [DATA_W-1:0]     acc_rdata,
   output logic                  acc_run,
   input  logic                  acc_done
);
   import m_stage_sched_pkg::*;

   localparam int               CNT_W   = $clog2(TIMEOUT + 1);
   localparam logic [6:0]       T_FIRST = 7'd16;
   localparam logic [6:0]       T_LAST  = 7'(16 + ROUNDS - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

   logic [2:0]            state_r;
   logic [1:0]            wr_ph_r;
   logic [1:0]            k_r;
   logic [6:0]            t_r;
   logic [CNT_W-1:0]      cnt_r;
   logic [DATA_W-1:0]     res_r;
   logic                  busy_r, fin_r, err_r;
   logic                  acc_valid_r, acc_run_r;
   logic [ACC_ADDR_W-1:0] acc_addr_r;
   logic [3:0]            acc_wstrb_r;
   logic [DATA_W-1:0]     acc_wdata_r;
   logic                  h_ready_r, hp_valid_r;
   logic [5:0]            hp_addr_r;

   logic                  seq_rd_s, hreq_s, hrd_want_s, hrd_go_s, hwr_go_s, cnt_hit_s;
   logic [5:0]            seq_addr_s, hrd_addr_s;
   logic                  buf_rd_en_s, buf_wr_en_s;
   logic [5:0]            buf_rd_addr_s, buf_wr_addr_s;
   logic [DATA_W-1:0]     buf_wr_data_s, buf_rd_data_s;

   // read-port arbitration (sequencer fetch wins, host read deferred) and write-port mux
   always_comb begin
      seq_addr_s = t_r[5:0] - tap_of(k_r);
      if (state_r == ST_WR && wr_ph_r == WR_FETCH) begin
         seq_rd_s = 1'b1;
      end else begin
         seq_rd_s = 1'b0;
      end
      hreq_s = h_valid & ~hp_valid_r;
      if (hp_valid_r) begin
         hrd_want_s = 1'b1;
         hrd_addr_s = hp_addr_r;
      end else begin
         hrd_want_s = hreq_s & ~h_we;
         hrd_addr_s = h_addr;
      end
      hrd_go_s      = hrd_want_s & ~seq_rd_s;
      hwr_go_s      = hreq_s & h_we & ~busy_r;
      buf_rd_en_s   = seq_rd_s | hrd_go_s;
      buf_rd_addr_s = seq_rd_s ? seq_addr_s : hrd_addr_s;
      if (state_r == ST_STORE) begin
         buf_wr_en_s   = 1'b1;
         buf_wr_addr_s = t_r[5:0];
         buf_wr_data_s = res_r;
      end else begin
         buf_wr_en_s   = hwr_go_s;
         buf_wr_addr_s = h_addr;
         buf_wr_data_s = h_wdata;
      end
      cnt_hit_s = (cnt_r == CNT_MAX);
   end

   m_stage_sched_buf #(.DATA_W(DATA_W)) u_buf (
      .clk     (clk),
      .rst     (rst),
      .rd_en   (buf_rd_en_s),
      .rd_addr (buf_rd_addr_s),
      .rd_data (buf_rd_data_s),
      .wr_en   (buf_wr_en_s),
      .wr_addr (buf_wr_addr_s),
      .wr_data (buf_wr_data_s)
   );

   // host ack; a read that lost arbitration is parked and served the next cycle
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         h_ready_r  <= 1'b0;
         hp_valid_r <= 1'b0;
         hp_addr_r  <= 6'd0;
      end else begin
         h_ready_r  <= hrd_go_s | (hreq_s & h_we);
         hp_valid_r <= hrd_want_s & seq_rd_s;
         if (hrd_want_s & seq_rd_s) begin
            hp_addr_r <= hrd_addr_s;
         end
      end
   end

   // sequencer FSM, timeout counter and registered accelerator outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r     <= ST_IDLE;
         wr_ph_r     <= WR_FETCH;
         k_r         <= 2'd0;
         t_r         <= T_FIRST;
         cnt_r       <= '0;
         res_r       <= '0;
         busy_r      <= 1'b0;
         fin_r       <= 1'b0;
         err_r       <= 1'b0;
         acc_valid_r <= 1'b0;
         acc_run_r   <= 1'b0;
         acc_addr_r  <= '0;
         acc_wstrb_r <= 4'h0;
         acc_wdata_r <= '0;
      end else begin
         fin_r     <= 1'b0;
         acc_run_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               cnt_r <= '0;
               if (start) begin
                  state_r <= ST_WR;
                  wr_ph_r <= WR_FETCH;
                  k_r     <= 2'd0;
                  t_r     <= T_FIRST;
                  busy_r  <= 1'b1;
                  err_r   <= 1'b0;
               end
            end
            ST_WR: begin
               if (!acc_ready && cnt_hit_s) begin
                  state_r     <= ST_FIN;
                  fin_r       <= 1'b1;
                  busy_r      <= 1'b0;
                  err_r       <= 1'b1;
                  acc_valid_r <= 1'b0;
                  cnt_r       <= '0;
               end else begin
                  cnt_r <= acc_ready ? '0 : cnt_r + 1'b1;
                  case (wr_ph_r)
                     WR_FETCH: wr_ph_r <= WR_LOAD;
                     WR_LOAD: begin
                        acc_valid_r <= 1'b1;
                        acc_addr_r  <= ACC_ADDR_W'(xreg_of(k_r));
                        acc_wstrb_r <= 4'hF;
                        acc_wdata_r <= buf_rd_data_s;
                        wr_ph_r     <= WR_HOLD;
                     end
                     WR_HOLD: begin
                        if (acc_ready) begin
                           acc_valid_r <= 1'b0;
                           if (k_r == 2'd3) begin
                              state_r   <= ST_RUN;
                              acc_run_r <= 1'b1;
                           end else begin
                              k_r     <= k_r + 2'd1;
                              wr_ph_r <= WR_FETCH;
                           end
                        end
                     end
                     default: wr_ph_r <= WR_FETCH;
                  endcase
               end
            end
            ST_RUN: begin
               cnt_r   <= '0;
               state_r <= ST_ARM;
            end
            // dead cycle: acc_done may still show the previous round's level
            ST_ARM: begin
               cnt_r   <= '0;
               state_r <= ST_WAIT;
            end
            ST_WAIT: begin
               if (acc_done) begin
                  state_r     <= ST_RD;
                  acc_valid_r <= 1'b1;
                  acc_addr_r  <= ACC_ADDR_W'(XREG_RES);
                  acc_wstrb_r <= 4'h0;
                  acc_wdata_r <= '0;
                  cnt_r       <= '0;
               end else if (cnt_hit_s) begin
                  state_r <= ST_FIN;
                  fin_r   <= 1'b1;
                  busy_r  <= 1'b0;
                  err_r   <= 1'b1;
                  cnt_r   <= '0;
               end else begin
                  cnt_r <= cnt_r + 1'b1;
               end
            end
            ST_RD: begin
               if (acc_ready) begin
                  res_r       <= acc_rdata;
                  acc_valid_r <= 1'b0;
                  state_r     <= ST_STORE;
                  cnt_r       <= '0;
               end else if (cnt_hit_s) begin
                  state_r     <= ST_FIN;
                  fin_r       <= 1'b1;
                  busy_r      <= 1'b0;
                  err_r       <= 1'b1;
                  acc_valid_r <= 1'b0;
                  cnt_r       <= '0;
               end else begin
                  cnt_r <= cnt_r + 1'b1;
               end
            end
            ST_STORE: begin
               cnt_r <= '0;
               if (t_r == T_LAST) begin
                  state_r <= ST_FIN;
                  fin_r   <= 1'b1;
                  busy_r  <= 1'b0;
               end else begin
                  t_r     <= t_r + 7'd1;
                  state_r <= ST_WR;
                  wr_ph_r <= WR_FETCH;
                  k_r     <= 2'd0;
               end
            end
            ST_FIN: begin
               cnt_r   <= '0;
               state_r <= ST_IDLE;
            end
            default: begin
               cnt_r   <= '0;
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy      = busy_r;
   assign fin       = fin_r;
   assign err       = err_r;
   assign h_rdata   = buf_rd_data_s;
   assign h_ready   = h_ready_r;
   assign acc_valid = acc_valid_r;
   assign acc_addr  = acc_addr_r;
   assign acc_wstrb = acc_wstrb_r;
   assign acc_wdata = acc_wdata_r;
   assign acc_run   = acc_run_r;

endmodule

// File: tb/tb_m_stage_sched.sv
// tb_m_stage_sched
// Directed bench for m_stage_sched with a behavioural M_Stage accelerator model
// (registered ack with optional random stalls, done cleared one cycle after the
// run pulse is sampled, result published with done after a fixed latency).
module tb_m_stage_sched;
   localparam int ROUNDS  = 48;
   localparam int TIMEOUT = 1023;
   localparam int LAT     = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start, busy, fin, err;
   logic        h_valid, h_we, h_ready;
   logic [5:0]  h_addr;
   logic [31:0] h_wdata, h_rdata;
   logic        acc_valid, acc_ready, acc_run;
   logic        acc_done = 1'b1;
   logic [2:0]  acc_addr;
   logic [3:0]  acc_wstrb;
   logic [31:0] acc_wdata, acc_rdata;

   int n_cmp = 0;
   int n_mis = 0;
   int run_total = 0;
   bit stall_en = 1'b0;
   bit never_done = 1'b0;

   logic [31:0] exp_w [0:63];
   logic [31:0] xr [0:3];
   logic [31:0] res_m;
   logic        run_q, calc;
   int          lat_left, stall_left;

   always #5 clk = ~clk;

   m_stage_sched #(.DATA_W(32), .ACC_ADDR_W(3), .ROUNDS(ROUNDS), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .fin(fin), .err(err),
      .h_valid(h_valid), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
      .h_rdata(h_rdata), .h_ready(h_ready),
      .acc_valid(acc_valid), .acc_addr(acc_addr), .acc_wstrb(acc_wstrb),
      .acc_wdata(acc_wdata), .acc_ready(acc_ready), .acc_rdata(acc_rdata),
      .acc_run(acc_run), .acc_done(acc_done)
   );

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      rotr = (x >> n) | (x << (32 - n));
   endfunction
   function automatic logic [31:0] sig0(input logic [31:0] x);
      sig0 = rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
   endfunction
   function automatic logic [31:0] sig1(input logic [31:0] x);
      sig1 = rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
   endfunction

   // accelerator model: bus slave, run/done handshake, result computation
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc_ready  <= 1'b0;
         acc_rdata  <= 32'd0;
         run_q      <= 1'b0;
         calc       <= 1'b0;
         stall_left <= 0;
         lat_left   <= 0;
      end else begin
         acc_ready <= 1'b0;
         if (acc_valid && !acc_ready) begin
            if (stall_left == 0) begin
               acc_ready  <= 1'b1;
               stall_left <= stall_en ? int'($urandom_range(5, 0)) : 0;
               if (acc_wstrb == 4'hF && acc_addr < 3'd4) xr[acc_addr[1:0]] <= acc_wdata;
               acc_rdata <= (acc_addr == 3'd4) ? res_m : 32'd0;
            end else begin
               stall_left <= stall_left - 1;
            end
         end
         run_q <= acc_run;
         if (acc_run) run_total <= run_total + 1;
         if (run_q) begin
            acc_done <= 1'b0;
            calc     <= 1'b1;
            lat_left <= LAT;
         end else if (calc) begin
            if (lat_left == 0) begin
               res_m    <= sig1(xr[3]) + xr[2] + sig0(xr[1]) + xr[0];
               acc_done <= ~never_done;
               calc     <= 1'b0;
            end else begin
               lat_left <= lat_left - 1;
            end
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_mis++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic build_exp();
      for (int t = 16; t < 64; t++)
         exp_w[t] = sig1(exp_w[t-2]) + exp_w[t-7] + sig0(exp_w[t-15]) + exp_w[t-16];
   endtask

   task automatic host_write(input logic [5:0] a, input logic [31:0] d);
      int n;
      @(negedge clk); h_valid = 1'b1; h_we = 1'b1; h_addr = a; h_wdata = d;
      @(negedge clk); h_valid = 1'b0; h_we = 1'b0;
      n = 0;
      while (h_ready !== 1'b1 && n < 8) begin @(negedge clk); n++; end
      chk("hwr_ack", 32'(h_ready), 32'd1);
   endtask

   task automatic host_read(input logic [5:0] a, output logic [31:0] d);
      int n;
      @(negedge clk); h_valid = 1'b1; h_we = 1'b0; h_addr = a;
      @(negedge clk); h_valid = 1'b0;
      n = 0;
      while (h_ready !== 1'b1 && n < 8) begin @(negedge clk); n++; end
      chk("hrd_ack", 32'(h_ready), 32'd1);
      d = h_rdata;
   endtask

   task automatic pulse_start();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
   endtask

   task automatic wait_fin(input int budget);
      int n;
      n = 0;
      while (fin !== 1'b1 && n < budget) begin @(negedge clk); n++; end
      chk("fin_seen", 32'(fin), 32'd1);
      chk("busy_at_fin", 32'(busy), 32'd0);
   endtask

   task automatic check_all(input string tag);
      logic [31:0] d;
      for (int i = 16; i < 64; i++) begin
         host_read(6'(i), d);
         chk($sformatf("%s_w%0d", tag, i), d, exp_w[i]);
      end
   endtask

   task automatic load_random();
      for (int i = 0; i < 16; i++) begin
         exp_w[i] = $urandom;
         host_write(6'(i), exp_w[i]);
      end
      build_exp();
   endtask

   initial begin
      logic [31:0] d;
      int r0, n;
      bit found;
      start = 1'b0; h_valid = 1'b0; h_we = 1'b0; h_addr = 6'd0; h_wdata = 32'd0;
      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_fin", 32'(fin), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_acc_valid", 32'(acc_valid), 32'd0);
      chk("rst_acc_run", 32'(acc_run), 32'd0);
      chk("rst_h_ready", 32'(h_ready), 32'd0);
      chk("rst_acc_addr", 32'(acc_addr), 32'd0);
      chk("rst_acc_wstrb", 32'(acc_wstrb), 32'd0);
      chk("rst_acc_wdata", acc_wdata, 32'd0);
      chk("rst_h_rdata", h_rdata, 32'd0);
      rst = 1'b1;

      // "abc" padded block
      for (int i = 0; i < 16; i++) exp_w[i] = 32'd0;
      exp_w[0] = 32'h61626380;
      exp_w[15] = 32'h00000018;
      for (int i = 0; i < 16; i++) host_write(6'(i), exp_w[i]);
      build_exp();
      host_read(6'd15, d);
      chk("abc_w15_readback", d, 32'h00000018);
      r0 = run_total;
      pulse_start();
      chk("abc_busy", 32'(busy), 32'd1);
      wait_fin(20000);
      chk("abc_err", 32'(err), 32'd0);
      chk("abc_rounds", 32'(run_total - r0), 32'(ROUNDS));
      host_read(6'd16, d);
      chk("abc_w16", d, 32'h61626380);
      host_read(6'd17, d);
      chk("abc_w17", d, 32'h000F0000);
      check_all("abc");

      // random block, stalled bus, host traffic and start while busy
      stall_en = 1'b1;
      load_random();
      r0 = run_total;
      pulse_start();
      repeat (30) @(negedge clk);
      host_write(6'd3, 32'hDEADBEEF);
      host_read(6'd0, d);
      chk("busy_read_w0", d, exp_w[0]);
      pulse_start();
      chk("start_busy_ignored", 32'(busy), 32'd1);
      wait_fin(20000);
      chk("rnd_err", 32'(err), 32'd0);
      chk("rnd_rounds", 32'(run_total - r0), 32'(ROUNDS));
      host_read(6'd3, d);
      chk("busy_write_dropped", d, exp_w[3]);
      check_all("rnd");

      // done never arrives: timeout abort
      stall_en = 1'b0;
      never_done = 1'b1;
      pulse_start();
      n = 0;
      while (acc_run !== 1'b1 && n < 200) begin @(negedge clk); n++; end
      chk("to_run_seen", 32'(acc_run), 32'd1);
      n = 0;
      do begin @(negedge clk); n++; end while (fin !== 1'b1 && n < 3000);
      chk("to_fin_delay", 32'(n), 32'(TIMEOUT + 2));
      chk("to_err", 32'(err), 32'd1);
      chk("to_busy", 32'(busy), 32'd0);
      chk("to_acc_valid", 32'(acc_valid), 32'd0);
      repeat (3) @(negedge clk);
      chk("to_err_sticky", 32'(err), 32'd1);
      never_done = 1'b0;
      pulse_start();
      chk("restart_err_clr", 32'(err), 32'd0);
      chk("restart_busy", 32'(busy), 32'd1);
      wait_fin(20000);
      chk("restart_err", 32'(err), 32'd0);
      check_all("restart");

      // reset while reading the result of round t=20
      stall_en = 1'b1;
      load_random();
      r0 = run_total;
      pulse_start();
      n = 0;
      found = 1'b0;
      while (!found && n < 5000) begin
         @(negedge clk); n++;
         found = (run_total - r0 == 5) && acc_valid === 1'b1 && acc_addr === 3'd4;
      end
      chk("rd20_found", 32'(found), 32'd1);
      #1 rst = 1'b0;
      #1;
      chk("mid_rst_acc_valid", 32'(acc_valid), 32'd0);
      chk("mid_rst_acc_run", 32'(acc_run), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_fin", 32'(fin), 32'd0);
      chk("mid_rst_acc_addr", 32'(acc_addr), 32'd0);
      @(negedge clk); rst = 1'b1;
      host_read(6'd19, d);
      chk("partial_w19", d, exp_w[19]);
      r0 = run_total;
      pulse_start();
      wait_fin(20000);
      chk("post_rst_err", 32'(err), 32'd0);
      chk("post_rst_rounds", 32'(run_total - r0), 32'(ROUNDS));
      check_all("postrst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
